// File: rtl/dsa_job_ctrl_pkg.sv
// Shared definitions for the bilinear downscaler job controller:
// register map, control/status bit positions, FSM states, reset config
// values and the job validation helper.
package dsa_job_ctrl_pkg;

  localparam logic [3:0] ADDR_CTRL   = 4'd0;
  localparam logic [3:0] ADDR_STATUS = 4'd1;
  localparam logic [3:0] ADDR_IN_W   = 4'd2;
  localparam logic [3:0] ADDR_IN_H   = 4'd3;
  localparam logic [3:0] ADDR_SCALE  = 4'd4;
  localparam logic [3:0] ADDR_NCH    = 4'd5;
  localparam logic [3:0] ADDR_OUT_W  = 4'd6;
  localparam logic [3:0] ADDR_OUT_H  = 4'd7;
  localparam logic [3:0] ADDR_CYCLES = 4'd8;

  localparam int CTRL_START  = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_ERR     = 2;
  localparam int ST_ABORTED = 3;

  localparam logic [15:0] RST_IN_W  = 16'd64;
  localparam logic [15:0] RST_IN_H  = 16'd64;
  localparam logic [15:0] RST_SCALE = 16'd205;
  localparam logic [15:0] RST_NCH   = 16'd1;

  // Largest legal scale factor in Q8.8 (1.0, i.e. no upscaling)
  localparam logic [15:0] SCALE_MAX = 16'd256;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    LAUNCH,
    WAIT,
    NEXT,
    ABORT
  } state_t;

  // A job is rejected when any dimension or the scale is zero, the scale
  // upscales, the plane does not fit the core address space, or the channel
  // count is outside 1..nch.
  function automatic logic job_invalid(input logic [15:0] w,
                                       input logic [15:0] h,
                                       input logic [15:0] s,
                                       input logic [15:0] n,
                                       input int          aw,
                                       input int          nch);
    logic [31:0] area;
    area = {16'd0, w} * {16'd0, h};
    return (w == 16'd0) || (h == 16'd0) || (s == 16'd0) || (s > SCALE_MAX) ||
           (area > (32'd1 << aw)) || (n == 16'd0) || (n > 16'(nch));
  endfunction

endpackage

// File: rtl/dsa_job_ctrl_reg_file.sv
// Host-visible register file: shadow config registers, CTRL strobes,
// sticky STATUS bits with write-one-to-clear, and a registered read port.
module dsa_job_ctrl_reg_file
  import dsa_job_ctrl_pkg::*;
(
  input  logic        clk_50,
  input  logic        rst_n,
  input  logic [3:0]  reg_addr_i,
  input  logic [31:0] reg_wdata_i,
  input  logic        reg_we_i,
  input  logic        reg_re_i,
  output logic [31:0] reg_rdata_o,
  output logic        reg_rvalid_o,
  output logic        start_req_o,
  output logic        abort_req_o,
  output logic        irq_o,
  output logic [15:0] in_w_o,
  output logic [15:0] in_h_o,
  output logic [15:0] scale_o,
  output logic [15:0] nch_act_o,
  input  logic        busy_i,
  input  logic [7:0]  ch_i,
  input  logic        done_set_i,
  input  logic        done_clr_i,
  input  logic        err_set_i,
  input  logic        aborted_set_i,
  input  logic [15:0] out_w_i,
  input  logic [15:0] out_h_i,
  input  logic [31:0] cycles_i
);

  logic [15:0] in_w_q, in_h_q, scale_q, nch_q;
  logic        irq_en_q;
  logic        done_q, err_q, aborted_q;
  logic        done_d, err_d, aborted_d;
  logic        ctrl_wr, status_wr;
  logic [31:0] rdata_d, rdata_q;
  logic        rvalid_q;
  logic        wdata_unused;

  assign wdata_unused = ^reg_wdata_i[31:16];

  assign ctrl_wr     = reg_we_i && (reg_addr_i == ADDR_CTRL);
  assign status_wr   = reg_we_i && (reg_addr_i == ADDR_STATUS);
  assign start_req_o = ctrl_wr && reg_wdata_i[CTRL_START];
  assign abort_req_o = ctrl_wr && reg_wdata_i[CTRL_ABORT];

  assign in_w_o       = in_w_q;
  assign in_h_o       = in_h_q;
  assign scale_o      = scale_q;
  assign nch_act_o    = nch_q;
  assign irq_o        = done_q & irq_en_q;
  assign reg_rdata_o  = rdata_q;
  assign reg_rvalid_o = rvalid_q;

  // Host writes to the shadow config registers and the IRQ enable
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      in_w_q   <= RST_IN_W;
      in_h_q   <= RST_IN_H;
      scale_q  <= RST_SCALE;
      nch_q    <= RST_NCH;
      irq_en_q <= 1'b0;
    end else if (reg_we_i) begin
      case (reg_addr_i)
        ADDR_CTRL:  irq_en_q <= reg_wdata_i[CTRL_IRQ_EN];
        ADDR_IN_W:  in_w_q   <= reg_wdata_i[15:0];
        ADDR_IN_H:  in_h_q   <= reg_wdata_i[15:0];
        ADDR_SCALE: scale_q  <= reg_wdata_i[15:0];
        ADDR_NCH:   nch_q    <= reg_wdata_i[15:0];
        default:    ;
      endcase
    end
  end

  // Sticky status bits: a hardware set in the same cycle beats any clear
  always_comb begin
    done_d    = done_set_i    | (done_q    & ~(status_wr & reg_wdata_i[ST_DONE]) & ~done_clr_i);
    err_d     = err_set_i     | (err_q     & ~(status_wr & reg_wdata_i[ST_ERR]));
    aborted_d = aborted_set_i | (aborted_q & ~(status_wr & reg_wdata_i[ST_ABORTED]));
  end

  // Status bit registers
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      done_q    <= done_d;
      err_q     <= err_d;
      aborted_q <= aborted_d;
    end
  end

  // Read mux; unmapped addresses read as zero
  always_comb begin
    rdata_d = '0;
    case (reg_addr_i)
      ADDR_CTRL:   rdata_d[CTRL_IRQ_EN] = irq_en_q;
      ADDR_STATUS: begin
        rdata_d[ST_BUSY]    = busy_i;
        rdata_d[ST_DONE]    = done_q;
        rdata_d[ST_ERR]     = err_q;
        rdata_d[ST_ABORTED] = aborted_q;
        rdata_d[15:8]       = ch_i;
      end
      ADDR_IN_W:   rdata_d = {16'd0, in_w_q};
      ADDR_IN_H:   rdata_d = {16'd0, in_h_q};
      ADDR_SCALE:  rdata_d = {16'd0, scale_q};
      ADDR_NCH:    rdata_d = {16'd0, nch_q};
      ADDR_OUT_W:  rdata_d = {16'd0, out_w_i};
      ADDR_OUT_H:  rdata_d = {16'd0, out_h_i};
      ADDR_CYCLES: rdata_d = cycles_i;
      default:     rdata_d = '0;
    endcase
  end

  // Read response one cycle after the strobe, data held at zero otherwise
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= reg_re_i ? rdata_d : 32'd0;
      rvalid_q <= reg_re_i;
    end
  end

endmodule

// File: rtl/dsa_job_ctrl.sv
// Job controller for one bilinear_seq core: latches the host config at
// START, validates it, runs the core once per colour channel, guards each
// run with a watchdog and reports completion, errors and aborts.
module dsa_job_ctrl
  import dsa_job_ctrl_pkg::*;
#(
  parameter  int AW      = 12,
  parameter  int NCH     = 3,
  parameter  int TIMEOUT = 2**20,
  localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk_50,
  input  logic            rst_n,
  input  logic [3:0]      reg_addr_i,
  input  logic [31:0]     reg_wdata_i,
  input  logic            reg_we_i,
  input  logic            reg_re_i,
  output logic [31:0]     reg_rdata_o,
  output logic            reg_rvalid_o,
  output logic            irq_o,
  output logic            core_start_o,
  output logic            core_srst_n_o,
  input  logic            core_busy_i,
  input  logic            core_done_i,
  output logic [15:0]     core_in_w_o,
  output logic [15:0]     core_in_h_o,
  output logic [15:0]     core_scale_o,
  input  logic [15:0]     core_out_w_i,
  input  logic [15:0]     core_out_h_i,
  output logic [CHW-1:0]  ch_sel_o
);

  state_t          state_q;
  logic [CHW-1:0]  ch_q, ch_sel_q;
  logic            core_start_q, srst_n_q, abort_cnt_q;
  logic [31:0]     wd_q, cycles_q;
  logic [15:0]     out_w_q, out_h_q;
  logic [15:0]     act_in_w_q, act_in_h_q, act_scale_q, act_nch_q;

  logic [15:0]     shd_in_w, shd_in_h, shd_scale, shd_nch;
  logic            start_req, abort_req;
  logic            start_ok, active, wd_expired, job_bad, last_ch, abort_hit;
  logic            done_set, done_clr, err_set, aborted_set;
  logic            unused_inputs;

  assign unused_inputs = core_busy_i;

  assign core_start_o  = core_start_q;
  assign core_srst_n_o = srst_n_q;
  assign ch_sel_o      = ch_sel_q;
  assign core_in_w_o   = act_in_w_q;
  assign core_in_h_o   = act_in_h_q;
  assign core_scale_o  = act_scale_q;

  dsa_job_ctrl_reg_file u_regs (
    .clk_50        (clk_50),
    .rst_n         (rst_n),
    .reg_addr_i    (reg_addr_i),
    .reg_wdata_i   (reg_wdata_i),
    .reg_we_i      (reg_we_i),
    .reg_re_i      (reg_re_i),
    .reg_rdata_o   (reg_rdata_o),
    .reg_rvalid_o  (reg_rvalid_o),
    .start_req_o   (start_req),
    .abort_req_o   (abort_req),
    .irq_o         (irq_o),
    .in_w_o        (shd_in_w),
    .in_h_o        (shd_in_h),
    .scale_o       (shd_scale),
    .nch_act_o     (shd_nch),
    .busy_i        (active),
    .ch_i          (8'(ch_q)),
    .done_set_i    (done_set),
    .done_clr_i    (done_clr),
    .err_set_i     (err_set),
    .aborted_set_i (aborted_set),
    .out_w_i       (out_w_q),
    .out_h_i       (out_h_q),
    .cycles_i      (cycles_q)
  );

  // Decisions shared by the FSM and the status-bit strobes
  always_comb begin
    start_ok    = start_req && !abort_req;
    active      = (state_q != IDLE);
    wd_expired  = (wd_q > 32'(TIMEOUT));
    job_bad     = job_invalid(act_in_w_q, act_in_h_q, act_scale_q, act_nch_q, AW, NCH);
    last_ch     = (16'(ch_q) == (act_nch_q - 16'd1));
    abort_hit   = (active && (state_q != ABORT) && abort_req) ||
                  ((state_q == WAIT) && !core_done_i && wd_expired);
    done_clr    = !active && start_ok;
    done_set    = (state_q == NEXT) && last_ch && !abort_hit;
    err_set     = ((state_q == CHECK) && job_bad && !abort_hit) ||
                  ((state_q == WAIT) && !core_done_i && wd_expired) ||
                  (active && start_ok);
    aborted_set = (state_q == ABORT) && abort_cnt_q;
  end

  // Job sequencer with cycle counter, watchdog and registered core controls
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ch_q         <= '0;
      ch_sel_q     <= '0;
      core_start_q <= 1'b0;
      srst_n_q     <= 1'b1;
      abort_cnt_q  <= 1'b0;
      wd_q         <= '0;
      cycles_q     <= '0;
      out_w_q      <= '0;
      out_h_q      <= '0;
      act_in_w_q   <= '0;
      act_in_h_q   <= '0;
      act_scale_q  <= '0;
      act_nch_q    <= '0;
    end else begin
      core_start_q <= 1'b0;
      if (active && (cycles_q != 32'hFFFF_FFFF)) cycles_q <= cycles_q + 32'd1;
      if (abort_hit) begin
        state_q     <= ABORT;
        srst_n_q    <= 1'b0;
        abort_cnt_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (start_ok) begin
            act_in_w_q  <= shd_in_w;
            act_in_h_q  <= shd_in_h;
            act_scale_q <= shd_scale;
            act_nch_q   <= shd_nch;
            cycles_q    <= '0;
            ch_q        <= '0;
            state_q     <= CHECK;
          end
          CHECK: if (job_bad) begin
            state_q <= IDLE;
          end else begin
            ch_sel_q     <= ch_q;
            core_start_q <= 1'b1;
            state_q      <= LAUNCH;
          end
          LAUNCH: begin
            wd_q    <= '0;
            state_q <= WAIT;
          end
          WAIT: if (core_done_i) begin
            out_w_q <= core_out_w_i;
            out_h_q <= core_out_h_i;
            state_q <= NEXT;
          end else begin
            wd_q <= wd_q + 32'd1;
          end
          NEXT: if (last_ch) begin
            state_q <= IDLE;
          end else begin
            ch_q         <= ch_q + 1'b1;
            ch_sel_q     <= ch_q + 1'b1;
            core_start_q <= 1'b1;
            state_q      <= LAUNCH;
          end
          ABORT: if (abort_cnt_q) begin
            srst_n_q <= 1'b1;
            state_q  <= IDLE;
          end else begin
            abort_cnt_q <= 1'b1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule
